reservation_station: RTL and testbench

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/reservation_station.sv | 138 +++++++++++++
 tb/tb_reservation_station.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// reservation_station
//   Holds up to ENTRIES issued operations while their operands are still
//   being produced. Waiting operands snoop the common data bus (CDB) and
//   capture the result whose tag they are waiting on. The lowest-index slot
//   with both operands present is offered to the functional unit.
//
// Ports
//   CLOCK_50, RESET      : clock (rising edge) and async active-high reset
//   issue_*              : issue request (valid/ready handshake); tag 0 means
//                          the accompanying value is already valid
//   cdb_valid/tag/data   : result broadcast, tag is never 0 when valid
//   disp_*               : dispatch offer (valid/ready handshake), values and
//                          slot index of the offered entry, zero when idle
//   occupancy            : registered count of busy slots
module reservation_station #(
  parameter int ENTRIES = 4,
  parameter int TAG_W   = 2,
  parameter int DATA_W  = 32
) (
  input  logic                      CLOCK_50,
  input  logic                      RESET,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [TAG_W-1:0]          issue_tag1,
  input  logic [DATA_W-1:0]         issue_val1,
  input  logic [TAG_W-1:0]          issue_tag2,
  input  logic [DATA_W-1:0]         issue_val2,
  input  logic                      cdb_valid,
  input  logic [TAG_W-1:0]          cdb_tag,
  input  logic [DATA_W-1:0]         cdb_data,
  output logic                      disp_valid,
  input  logic                      disp_ready,
  output logic [DATA_W-1:0]         disp_value1,
  output logic [DATA_W-1:0]         disp_value2,
  output logic [$clog2(ENTRIES)-1:0] disp_slot,
  output logic [$clog2(ENTRIES):0]   occupancy
);

  localparam int SLOT_W = $clog2(ENTRIES);
  localparam int CNT_W  = SLOT_W + 1;

  logic [ENTRIES-1:0] busy;
  logic [TAG_W-1:0]   tag1 [ENTRIES];
  logic [TAG_W-1:0]   tag2 [ENTRIES];
  logic [DATA_W-1:0]  val1 [ENTRIES];
  logic [DATA_W-1:0]  val2 [ENTRIES];

  logic [ENTRIES-1:0] slot_rdy;
  logic               free_found;
  logic [SLOT_W-1:0]  free_idx;
  logic [SLOT_W-1:0]  rdy_idx;
  logic               accept;
  logic               dispatch;

  logic               byp1, byp2;
  logic [TAG_W-1:0]   in_tag1, in_tag2;
  logic [DATA_W-1:0]  in_val1, in_val2;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    rdy_idx    = '0;
    slot_rdy   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      slot_rdy[i] = busy[i] && (tag1[i] == '0) && (tag2[i] == '0);
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(i);
      end
      if (slot_rdy[i]) begin
        rdy_idx = SLOT_W'(i);
      end
    end
  end

  // Free-slot status comes from registered busy bits only, so a dispatch in
  // this cycle cannot make room for an issue in the same cycle.
  assign issue_ready = free_found;
  assign disp_valid  = |slot_rdy;
  assign accept      = issue_valid && issue_ready;
  assign dispatch    = disp_valid && disp_ready;

  assign disp_value1 = disp_valid ? val1[rdy_idx] : '0;
  assign disp_value2 = disp_valid ? val2[rdy_idx] : '0;
  assign disp_slot   = disp_valid ? rdy_idx : '0;

  // Issue/CDB bypass: an operand whose producer broadcasts this very cycle
  // is written as already present. Tag 0 never matches.
  always_comb begin
    byp1    = cdb_valid && (issue_tag1 != '0) && (issue_tag1 == cdb_tag);
    byp2    = cdb_valid && (issue_tag2 != '0) && (issue_tag2 == cdb_tag);
    in_tag1 = byp1 ? '0 : issue_tag1;
    in_tag2 = byp2 ? '0 : issue_tag2;
    in_val1 = byp1 ? cdb_data : issue_val1;
    in_val2 = byp2 ? cdb_data : issue_val2;
  end

  // The dispatched slot is ready (tags 0, no CDB match) and the issued slot
  // was free, so dispatch, issue and capture never touch the same fields.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      busy      <= '0;
      occupancy <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag1[i] <= '0;
        tag2[i] <= '0;
        val1[i] <= '0;
        val2[i] <= '0;
      end
    end else begin
      occupancy <= occupancy + CNT_W'(accept) - CNT_W'(dispatch);
      for (int i = 0; i < ENTRIES; i++) begin
        if (dispatch && (rdy_idx == SLOT_W'(i))) begin
          busy[i] <= 1'b0;
          tag1[i] <= '0;
          tag2[i] <= '0;
        end else if (accept && (free_idx == SLOT_W'(i))) begin
          busy[i] <= 1'b1;
          tag1[i] <= in_tag1;
          tag2[i] <= in_tag2;
          val1[i] <= in_val1;
          val2[i] <= in_val2;
        end else if (busy[i] && cdb_valid) begin
          if ((tag1[i] != '0) && (tag1[i] == cdb_tag)) begin
            tag1[i] <= '0;
            val1[i] <= cdb_data;
          end
          if ((tag2[i] != '0) && (tag2[i] == cdb_tag)) begin
            tag2[i] <= '0;
            val2[i] <= cdb_data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
module tb_reservation_station;

  localparam int ENTRIES = 4;
  localparam int TAG_W   = 2;
  localparam int DATA_W  = 32;

  logic              CLOCK_50 = 1'b0;
  logic              RESET;
  logic              issue_valid;
  logic              issue_ready;
  logic [TAG_W-1:0]  issue_tag1, issue_tag2;
  logic [DATA_W-1:0] issue_val1, issue_val2;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              disp_valid;
  logic              disp_ready;
  logic [DATA_W-1:0] disp_value1, disp_value2;
  logic [1:0]        disp_slot;
  logic [2:0]        occupancy;

  int checks = 0;
  int errors = 0;

  reservation_station #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_tag1(issue_tag1), .issue_val1(issue_val1),
    .issue_tag2(issue_tag2), .issue_val2(issue_val2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_value1(disp_value1), .disp_value2(disp_value2),
    .disp_slot(disp_slot), .occupancy(occupancy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #400000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic rdy, input logic dv,
                         input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] slot, input logic [31:0] occ);
    chk({tag, ".issue_ready"}, 32'(issue_ready), 32'(rdy));
    chk({tag, ".disp_valid"},  32'(disp_valid),  32'(dv));
    chk({tag, ".disp_value1"}, disp_value1, v1);
    chk({tag, ".disp_value2"}, disp_value2, v2);
    chk({tag, ".disp_slot"},   32'(disp_slot), slot);
    chk({tag, ".occupancy"},   32'(occupancy), occ);
  endtask

  task automatic drive(input logic iv, input int t1, input int v1, input int t2, input int v2,
                       input logic cv, input int ct, input int cd, input logic dr);
    issue_valid = iv;
    issue_tag1  = TAG_W'(t1);
    issue_val1  = DATA_W'(v1);
    issue_tag2  = TAG_W'(t2);
    issue_val2  = DATA_W'(v2);
    cdb_valid   = cv;
    cdb_tag     = TAG_W'(ct);
    cdb_data    = DATA_W'(cd);
    disp_ready  = dr;
  endtask

  task automatic idle(input logic dr);
    drive(1'b0, 0, 0, 0, 0, 1'b0, 0, 0, dr);
  endtask

  typedef struct {
    logic iv; int t1; int v1; int t2; int v2;
    logic cv; int ct; int cd; logic dr;
    logic e_rdy; logic e_dv; int e_v1; int e_v2; int e_slot; int e_occ;
  } vec_t;

  // Reference model: a list of slots, updated from the rules directly.
  typedef struct {
    bit busy; int t1; int t2; logic [31:0] v1; logic [31:0] v2;
  } slot_t;
  slot_t m [ENTRIES];

  function automatic int m_first_free();
    for (int i = 0; i < ENTRIES; i++) if (!m[i].busy) return i;
    return -1;
  endfunction

  function automatic int m_first_ready();
    for (int i = 0; i < ENTRIES; i++)
      if (m[i].busy && m[i].t1 == 0 && m[i].t2 == 0) return i;
    return -1;
  endfunction

  function automatic int m_count();
    int n = 0;
    foreach (m[i]) if (m[i].busy) n++;
    return n;
  endfunction

  task automatic m_clear();
    foreach (m[i]) m[i] = '{0, 0, 0, 32'd0, 32'd0};
  endtask

  task automatic m_step();
    slot_t nxt [ENTRIES];
    int fi = m_first_free();
    int ri = m_first_ready();
    nxt = m;
    if (cdb_valid) begin
      foreach (m[i]) begin
        if (m[i].busy && m[i].t1 != 0 && m[i].t1 == int'(cdb_tag)) begin
          nxt[i].t1 = 0; nxt[i].v1 = cdb_data;
        end
        if (m[i].busy && m[i].t2 != 0 && m[i].t2 == int'(cdb_tag)) begin
          nxt[i].t2 = 0; nxt[i].v2 = cdb_data;
        end
      end
    end
    if (ri >= 0 && disp_ready) begin
      nxt[ri].busy = 0; nxt[ri].t1 = 0; nxt[ri].t2 = 0;
    end
    if (issue_valid && fi >= 0) begin
      nxt[fi].busy = 1;
      nxt[fi].t1 = int'(issue_tag1);
      nxt[fi].v1 = issue_val1;
      nxt[fi].t2 = int'(issue_tag2);
      nxt[fi].v2 = issue_val2;
      if (cdb_valid && issue_tag1 != 0 && issue_tag1 == cdb_tag) begin
        nxt[fi].t1 = 0; nxt[fi].v1 = cdb_data;
      end
      if (cdb_valid && issue_tag2 != 0 && issue_tag2 == cdb_tag) begin
        nxt[fi].t2 = 0; nxt[fi].v2 = cdb_data;
      end
    end
    m = nxt;
  endtask

  vec_t vecs [9];

  initial begin
    int ri;
    int occ_ref;
    // iv t1 v1 t2 v2 | cv ct cd | dr || rdy dv v1 v2 slot occ
    vecs[0] = '{1, 0, 5, 0, 7,   0, 0, 0,   1,  1, 0, 0, 0, 0, 0};
    vecs[1] = '{0, 0, 0, 0, 0,   0, 0, 0,   1,  1, 1, 5, 7, 0, 1};
    vecs[2] = '{1, 1, 0, 0, 3,   0, 0, 0,   1,  1, 0, 0, 0, 0, 0};
    vecs[3] = '{0, 0, 0, 0, 0,   0, 0, 0,   1,  1, 0, 0, 0, 0, 1};
    vecs[4] = '{0, 0, 0, 0, 0,   1, 1, 10,  1,  1, 0, 0, 0, 0, 1};
    vecs[5] = '{0, 0, 0, 0, 0,   0, 0, 0,   1,  1, 1, 10, 3, 0, 1};
    vecs[6] = '{1, 0, 1, 1, 0,   1, 1, 42,  1,  1, 0, 0, 0, 0, 0};
    vecs[7] = '{0, 0, 0, 0, 0,   0, 0, 0,   1,  1, 1, 1, 42, 0, 1};
    vecs[8] = '{0, 0, 0, 0, 0,   0, 0, 0,   1,  1, 0, 0, 0, 0, 0};

    RESET = 1'b1;
    idle(1'b0);
    #2;
    chk_out("reset", 1'b1, 1'b0, 0, 0, 0, 0);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    RESET = 1'b0;

    // Directed table: simple dispatch, CDB wake-up, issue/CDB bypass.
    for (int k = 0; k < 9; k++) begin
      drive(vecs[k].iv, vecs[k].t1, vecs[k].v1, vecs[k].t2, vecs[k].v2,
            vecs[k].cv, vecs[k].ct, vecs[k].cd, vecs[k].dr);
      #1;
      chk_out($sformatf("vec%0d", k), vecs[k].e_rdy, vecs[k].e_dv,
              vecs[k].e_v1, vecs[k].e_v2, vecs[k].e_slot, vecs[k].e_occ);
      @(negedge CLOCK_50);
    end

    // Fill all slots with the FU stalled.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 0, k + 1, 0, 50, 1'b0, 0, 0, 1'b0);
      #1;
      chk($sformatf("fill%0d.issue_ready", k), 32'(issue_ready), 32'd1);
      @(negedge CLOCK_50);
    end
    drive(1'b1, 0, 99, 0, 99, 1'b0, 0, 0, 1'b0);
    #1;
    chk_out("full", 1'b0, 1'b1, 1, 50, 0, 4);
    @(negedge CLOCK_50);
    disp_ready = 1'b1;
    #1;
    chk_out("full_disp", 1'b0, 1'b1, 1, 50, 0, 4);
    @(negedge CLOCK_50);
    idle(1'b0);
    #1;
    chk_out("after_disp", 1'b1, 1'b1, 2, 50, 1, 3);
    @(negedge CLOCK_50);
    idle(1'b1);
    repeat (3) @(negedge CLOCK_50);
    idle(1'b0);
    #1;
    chk("drained.occupancy", 32'(occupancy), 32'd0);

    // Two slots waiting on the same tag, one unrelated slot in between.
    drive(1'b1, 2, 0, 0, 100, 1'b0, 0, 0, 1'b0);
    @(negedge CLOCK_50);
    drive(1'b1, 3, 0, 0, 101, 1'b0, 0, 0, 1'b0);
    @(negedge CLOCK_50);
    drive(1'b1, 0, 200, 2, 0, 1'b0, 0, 0, 1'b0);
    @(negedge CLOCK_50);
    drive(1'b0, 0, 0, 0, 0, 1'b1, 2, 9, 1'b0);
    #1;
    chk_out("wait2", 1'b1, 1'b0, 0, 0, 0, 3);
    @(negedge CLOCK_50);
    idle(1'b1);
    #1;
    chk_out("wake_s0", 1'b1, 1'b1, 9, 100, 0, 3);
    @(negedge CLOCK_50);
    idle(1'b0);
    #1;
    chk_out("wake_s2", 1'b1, 1'b1, 200, 9, 2, 2);

    // Three busy slots, then an asynchronous reset between edges.
    drive(1'b1, 1, 0, 1, 0, 1'b0, 0, 0, 1'b0);
    @(negedge CLOCK_50);
    idle(1'b1);
    #2;
    chk("pre_reset.occupancy", 32'(occupancy), 32'd3);
    RESET = 1'b1;
    #1;
    chk_out("async_reset", 1'b1, 1'b0, 0, 0, 0, 0);
    @(posedge CLOCK_50);
    #1;
    chk_out("held_reset", 1'b1, 1'b0, 0, 0, 0, 0);
    @(negedge CLOCK_50);
    RESET = 1'b0;
    drive(1'b1, 0, 11, 0, 12, 1'b0, 0, 0, 1'b0);
    @(posedge CLOCK_50);
    #1;
    chk_out("first_issue", 1'b1, 1'b1, 11, 12, 0, 1);

    // Randomized run against the reference model.
    @(negedge CLOCK_50);
    idle(1'b0);
    RESET = 1'b1;
    @(negedge CLOCK_50);
    RESET = 1'b0;
    m_clear();
    occ_ref = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge CLOCK_50);
      issue_valid = ($urandom_range(0, 9) < 6);
      issue_tag1  = ($urandom_range(0, 1) == 0) ? TAG_W'(0) : TAG_W'($urandom_range(1, 3));
      issue_tag2  = ($urandom_range(0, 1) == 0) ? TAG_W'(0) : TAG_W'($urandom_range(1, 3));
      issue_val1  = $urandom;
      issue_val2  = $urandom;
      cdb_valid   = ($urandom_range(0, 1) == 1);
      cdb_tag     = TAG_W'($urandom_range(1, 3));
      cdb_data    = $urandom;
      disp_ready  = ($urandom_range(0, 9) < 4);
      #1;
      ri = m_first_ready();
      chk("rnd.issue_ready", 32'(issue_ready), 32'(m_first_free() >= 0));
      chk("rnd.disp_valid", 32'(disp_valid), 32'(ri >= 0));
      chk("rnd.disp_value1", disp_value1, (ri >= 0) ? m[ri].v1 : 32'd0);
      chk("rnd.disp_value2", disp_value2, (ri >= 0) ? m[ri].v2 : 32'd0);
      chk("rnd.disp_slot", 32'(disp_slot), (ri >= 0) ? 32'(ri) : 32'd0);
      chk("rnd.occupancy", 32'(occupancy), 32'(occ_ref));
      @(posedge CLOCK_50);
      m_step();
      occ_ref = m_count();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
